led_chase_monitor: RTL

Reader-side checker for the 8-bit LED chaser output. It samples the LED bus every CLK and tracks the load / rotate / stop sequence. It checks that each change is a legal one-place right rotation arriving at the nominal step interval, and reports step count, rotation phase, run/stop status and a sticky error code. It sits beside the chaser on the board (or in the bench) and observes its LED bus directly.

---
 rtl/led_chase_monitor.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/led_chase_monitor.sv
`default_nettype none
// ============================================================================
// Module      : led_chase_monitor
// Description : Observes an 8-bit LED chaser bus and checks each pattern
//               change. A legal change is a one-place right rotation
//               arriving within T_STEP +/- TOL cycles of the previous one.
//               Reports step count, rotation phase, run/stop status and a
//               sticky first-fault error code.
// Revision    : 1.0  initial release
// ============================================================================
module led_chase_monitor #(
  parameter int unsigned T_STEP   = 2_500_000,
  parameter int unsigned TOL      = 1_000,
  parameter logic [7:0]  LOAD_PAT = 8'h0F
) (
  input  logic        CLK,
  input  logic        start,
  input  logic [7:0]  LED_In,
  input  logic        clr,
  output logic        running,
  output logic        stop_seen,
  output logic [15:0] step_cnt,
  output logic [2:0]  rot_pos,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [31:0] c_ivl_min   = 32'(T_STEP - TOL);
  localparam logic [31:0] c_ivl_max   = 32'(T_STEP + TOL);
  localparam logic [31:0] c_ivl_stall = 32'(T_STEP + TOL + 1);

  localparam logic [1:0] c_code_load   = 2'd1;
  localparam logic [1:0] c_code_timing = 2'd2;
  localparam logic [1:0] c_code_pat    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STOP  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_d;
  logic [7:0]  r_led_q;
  logic [7:0]  r_led_prev;
  logic [31:0] r_ivl;
  logic        r_running;
  logic        r_stop_seen;
  logic [15:0] r_step_cnt;
  logic [2:0]  r_rot_pos;
  logic        r_err;
  logic [1:0]  r_err_code;

  logic        w_change;
  logic [7:0]  w_rot;
  logic        w_ivl_ok;
  logic        w_stop_seen_d;
  logic [15:0] w_step_cnt_d;
  logic [2:0]  w_rot_pos_d;
  logic        w_err_d;
  logic [1:0]  w_err_code_d;

  // r_ivl counts from 1 at a change, so at the next change it holds the
  // number of cycles between the two changes.
  assign w_change = (r_led_q != r_led_prev);
  assign w_rot    = {r_led_prev[0], r_led_prev[7:1]};
  assign w_ivl_ok = (r_ivl >= c_ivl_min) && (r_ivl <= c_ivl_max);

  // Bus sampling and saturating change-interval counter.
  always_ff @(posedge CLK or negedge start) begin
    if (!start) begin
      r_led_q    <= 8'd0;
      r_led_prev <= 8'd0;
      r_ivl      <= 32'd0;
    end else begin
      r_led_q    <= LED_In;
      r_led_prev <= r_led_q;
      if (w_change) begin
        r_ivl <= 32'd1;
      end else if (r_ivl != 32'hFFFF_FFFF) begin
        r_ivl <= r_ivl + 32'd1;
      end
    end
  end

  // State register and registered status outputs.
  always_ff @(posedge CLK or negedge start) begin
    if (!start) begin
      r_state     <= S_IDLE;
      r_running   <= 1'b0;
      r_stop_seen <= 1'b0;
      r_step_cnt  <= 16'd0;
      r_rot_pos   <= 3'd0;
      r_err       <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      r_state     <= w_state_d;
      r_running   <= (w_state_d == S_RUN);
      r_stop_seen <= w_stop_seen_d;
      r_step_cnt  <= w_step_cnt_d;
      r_rot_pos   <= w_rot_pos_d;
      r_err       <= w_err_d;
      r_err_code  <= w_err_code_d;
    end
  end

  // Next-state and status evaluation; clr overrides any pending change.
  always_comb begin
    w_state_d     = r_state;
    w_stop_seen_d = r_stop_seen;
    w_step_cnt_d  = r_step_cnt;
    w_rot_pos_d   = r_rot_pos;
    w_err_d       = r_err;
    w_err_code_d  = r_err_code;
    if (clr) begin
      w_state_d     = S_IDLE;
      w_stop_seen_d = 1'b0;
      w_step_cnt_d  = 16'd0;
      w_rot_pos_d   = 3'd0;
      w_err_d       = 1'b0;
      w_err_code_d  = 2'd0;
    end else begin
      case (r_state)
        S_IDLE, S_STOP: begin
          // Return to zero is harmless here; only LOAD_PAT may start a run.
          if (w_change) begin
            if (r_led_q == LOAD_PAT) begin
              w_state_d    = S_RUN;
              w_step_cnt_d = 16'd0;
              w_rot_pos_d  = 3'd0;
            end else if (r_led_q != 8'd0) begin
              w_state_d    = S_FAULT;
              w_err_d      = 1'b1;
              w_err_code_d = c_code_load;
            end
          end
        end
        S_RUN: begin
          if (w_change) begin
            if (r_led_q == w_rot) begin
              if (w_ivl_ok) begin
                if (r_step_cnt != 16'hFFFF) begin
                  w_step_cnt_d = r_step_cnt + 16'd1;
                end
                w_rot_pos_d = r_rot_pos + 3'd1;
              end else begin
                w_state_d    = S_FAULT;
                w_err_d      = 1'b1;
                w_err_code_d = c_code_timing;
              end
            end else if (r_led_q == 8'd0) begin
              w_state_d     = S_STOP;
              w_stop_seen_d = 1'b1;
            end else begin
              w_state_d    = S_FAULT;
              w_err_d      = 1'b1;
              w_err_code_d = c_code_pat;
            end
          end else if (r_ivl >= c_ivl_stall) begin
            // Chaser stalled: no change within the tolerance window.
            w_state_d    = S_FAULT;
            w_err_d      = 1'b1;
            w_err_code_d = c_code_timing;
          end
        end
        default: begin
          // S_FAULT: everything frozen until clr or reset.
        end
      endcase
    end
  end

  assign running   = r_running;
  assign stop_seen = r_stop_seen;
  assign step_cnt  = r_step_cnt;
  assign rot_pos   = r_rot_pos;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule
`default_nettype wire
